// File: rtl/rand_collect.sv
// rand_collect: buffers an unthrottled random-word stream in a small FIFO and
// reports XOR checksum, unsigned max and drop flag for every BATCH input words.
module rand_collect #(
   parameter int DEPTH = 4,
   parameter int BATCH = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic        rep_valid,
   output logic [31:0] rep_checksum,
   output logic [31:0] rep_max,
   output logic        rep_ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(BATCH) + 1;
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;
   logic [31:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic push, pop, drop;
   state_t state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [31:0] chk, chk_d, mx, mx_d;
   logic ovf, ovf_d, fresh, clr, last;
   assign out_valid = count != '0;
   assign out_data = mem[rd_ptr];
   assign pop = out_valid && out_ready;
   assign push = in_valid && (count != FULL || pop);
   assign drop = in_valid && !push;
   assign rep_valid = state == REPORT;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= in_data;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      end
   end
   // A batch starts on any word seen outside COLLECT; dropped words still count.
   always_comb begin
      fresh = in_valid && state != COLLECT;
      clr = !in_valid && state == REPORT;
      last = in_valid && (fresh ? (BATCH == 1) : (cnt == CW'(BATCH - 1)));
      cnt_d = clr ? '0 : fresh ? CW'(1) : cnt + CW'(in_valid);
      chk_d = clr ? '0 : fresh ? in_data : in_valid ? chk ^ in_data : chk;
      mx_d = clr ? '0 : (fresh || (in_valid && in_data > mx)) ? in_data : mx;
      ovf_d = clr ? 1'b0 : fresh ? drop : ovf | drop;
      state_d = last ? REPORT : in_valid ? COLLECT : clr ? IDLE : state;
   end
   always_ff @(posedge clk) state <= !rst_n ? IDLE : state_d;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         chk <= '0;
         mx <= '0;
         ovf <= 1'b0;
         rep_checksum <= '0;
         rep_max <= '0;
         rep_ovf <= 1'b0;
      end else begin
         cnt <= cnt_d;
         chk <= chk_d;
         mx <= mx_d;
         ovf <= ovf_d;
         if (last) begin
            rep_checksum <= chk_d;
            rep_max <= mx_d;
            rep_ovf <= ovf_d;
         end
      end
   end
endmodule

// File: tb/tb_rand_collect.sv
// tb_rand_collect: scoreboard bench for rand_collect; a negedge monitor models
// the FIFO and batch statistics while each scenario task checks its own points.
module tb_rand_collect;
   localparam int DEPTH = 4;
   localparam int BATCH = 256;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_data = '0;
   logic out_valid, rep_valid, rep_ovf;
   logic [31:0] out_data, rep_checksum, rep_max;
   int compared = 0, mismatched = 0;
   rand_collect #(.DEPTH(DEPTH), .BATCH(BATCH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .rep_valid(rep_valid), .rep_checksum(rep_checksum), .rep_max(rep_max),
      .rep_ovf(rep_ovf)
   );
   always #5 clk = ~clk;
   logic [31:0] sq [$];
   int m_n;
   logic [31:0] m_chk, m_max, e_chk, e_max;
   logic m_ovf, e_ovf, e_rv, m_pop, m_drop;
   bit armed = 0;
   // Reference model: sees the inputs of the coming edge and checks the state of the last one.
   always @(negedge clk) begin
      if (armed) begin
         compared++;
         if (out_valid !== (sq.size() != 0)) begin
            mismatched++;
            $display("FAIL sb_out_valid t=%0t: got %b want %b", $time, out_valid, sq.size() != 0);
         end
         if (sq.size() != 0) begin
            compared++;
            if (out_data !== sq[0]) begin
               mismatched++;
               $display("FAIL sb_out_data t=%0t: got %h want %h", $time, out_data, sq[0]);
            end
         end
         compared++;
         if (rep_valid !== e_rv || rep_checksum !== e_chk || rep_max !== e_max || rep_ovf !== e_ovf) begin
            mismatched++;
            $display("FAIL sb_report t=%0t: got v=%b chk=%h max=%h ovf=%b want v=%b chk=%h max=%h ovf=%b",
                     $time, rep_valid, rep_checksum, rep_max, rep_ovf, e_rv, e_chk, e_max, e_ovf);
         end
      end
      e_rv = 1'b0;
      if (!rst_n) begin
         sq.delete();
         m_n = 0; m_chk = '0; m_max = '0; m_ovf = 1'b0;
         e_chk = '0; e_max = '0; e_ovf = 1'b0;
         armed = 1;
      end else begin
         m_pop = sq.size() != 0 && out_ready;
         m_drop = in_valid && sq.size() == DEPTH && !m_pop;
         if (m_pop) void'(sq.pop_front());
         if (in_valid && !m_drop) sq.push_back(in_data);
         if (in_valid) begin
            m_n++;
            m_chk ^= in_data;
            if (in_data > m_max) m_max = in_data;
            m_ovf |= m_drop;
            if (m_n == BATCH) begin
               e_rv = 1'b1; e_chk = m_chk; e_max = m_max; e_ovf = m_ovf;
               m_n = 0; m_chk = '0; m_max = '0; m_ovf = 1'b0;
            end
         end
      end
   end
   task automatic drive(input logic v, input logic [31:0] d, input logic r);
      in_valid = v; in_data = d; out_ready = r;
      @(posedge clk); #1;
   endtask
   task automatic test_reset;
      rst_n = 0; drive(0, 0, 0); drive(0, 0, 0); rst_n = 1;
      compared++;
      if (out_valid !== 1'b0 || rep_valid !== 1'b0) begin
         mismatched++; $display("FAIL reset_valids: got out_valid=%b rep_valid=%b want 0 0", out_valid, rep_valid);
      end
      compared++;
      if (rep_checksum !== 32'h0 || rep_max !== 32'h0 || rep_ovf !== 1'b0) begin
         mismatched++; $display("FAIL reset_report: got chk=%h max=%h ovf=%b want 0 0 0", rep_checksum, rep_max, rep_ovf);
      end
   endtask
   task automatic test_basic;
      for (int i = 1; i <= 256; i++) begin
         drive(1, 32'(i), 1);
         compared++;
         if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
            mismatched++; $display("FAIL basic_latency word %0d: got v=%b d=%h want 1 %h", i, out_valid, out_data, 32'(i));
         end
      end
      compared++;
      if (rep_valid !== 1'b1 || rep_checksum !== 32'h100 || rep_max !== 32'd256 || rep_ovf !== 1'b0) begin
         mismatched++; $display("FAIL basic_report: got v=%b chk=%h max=%h ovf=%b want 1 00000100 00000100 0", rep_valid, rep_checksum, rep_max, rep_ovf);
      end
      drive(0, 0, 1);
      compared++;
      if (rep_valid !== 1'b0 || rep_checksum !== 32'h100 || rep_max !== 32'd256) begin
         mismatched++; $display("FAIL basic_hold: got v=%b chk=%h max=%h want 0 00000100 00000100", rep_valid, rep_checksum, rep_max);
      end
   endtask
   task automatic test_overflow;
      drive(0, 0, 1);
      for (int i = 0; i < 6; i++) drive(1, 32'hA0 + 32'(i), 0);
      compared++;
      if (out_valid !== 1'b1 || out_data !== 32'hA0) begin
         mismatched++; $display("FAIL ovf_head: got v=%b d=%h want 1 000000a0", out_valid, out_data);
      end
      for (int k = 1; k <= 4; k++) begin
         drive(0, 0, 1);
         compared++;
         if (k < 4 ? (out_valid !== 1'b1 || out_data !== 32'hA0 + 32'(k)) : (out_valid !== 1'b0)) begin
            mismatched++; $display("FAIL ovf_drain step %0d: got v=%b d=%h want v=%b d=%h", k, out_valid, out_data, k < 4, 32'hA0 + 32'(k));
         end
      end
      for (int i = 0; i < 250; i++) drive(1, 32'h1000 + 32'(i), 1);
      compared++;
      if (rep_valid !== 1'b1 || rep_ovf !== 1'b1) begin
         mismatched++; $display("FAIL ovf_report: got v=%b ovf=%b want 1 1", rep_valid, rep_ovf);
      end
   endtask
   task automatic test_full_push_pop;
      drive(0, 0, 1);
      for (int i = 0; i < 4; i++) drive(1, 32'hB0 + 32'(i), 0);
      drive(1, 32'hB4, 1);
      compared++;
      if (out_valid !== 1'b1 || out_data !== 32'hB1) begin
         mismatched++; $display("FAIL fpp_head: got v=%b d=%h want 1 000000b1", out_valid, out_data);
      end
      for (int k = 1; k <= 4; k++) begin
         drive(0, 0, 1);
         compared++;
         if (k < 4 ? (out_valid !== 1'b1 || out_data !== 32'hB1 + 32'(k)) : (out_valid !== 1'b0)) begin
            mismatched++; $display("FAIL fpp_drain step %0d: got v=%b d=%h want v=%b d=%h", k, out_valid, out_data, k < 4, 32'hB1 + 32'(k));
         end
      end
      for (int i = 0; i < 251; i++) drive(1, 32'h2000 + 32'(i), 1);
      compared++;
      if (rep_valid !== 1'b1 || rep_ovf !== 1'b0) begin
         mismatched++; $display("FAIL fpp_report: got v=%b ovf=%b want 1 0", rep_valid, rep_ovf);
      end
   endtask
   task automatic test_back_to_back;
      int p [$];
      logic [31:0] x, d;
      x = '0;
      drive(0, 0, 1);
      for (int i = 1; i <= 512; i++) begin
         d = 32'(i) * 32'h9E3779B1;
         if (i > 256) x ^= d;
         drive(1, d, 1);
         if (rep_valid === 1'b1) p.push_back(i);
      end
      compared++;
      if (p.size() != 2 || p[0] != 256 || p[1] - p[0] != 256) begin
         mismatched++; $display("FAIL b2b_pulses: got %0d pulses first=%0d last=%0d want 2 at 256 and 512", p.size(), p.size() > 0 ? p[0] : -1, p.size() > 0 ? p[p.size()-1] : -1);
      end
      compared++;
      if (rep_checksum !== x) begin
         mismatched++; $display("FAIL b2b_checksum: got %h want %h", rep_checksum, x);
      end
   endtask
   task automatic test_unsigned_max;
      logic [31:0] d;
      drive(0, 0, 1);
      for (int i = 0; i < 256; i++) begin
         d = (i == 10) ? 32'h7FFFFFFF : (i == 200) ? 32'hFFFFFFFF : ($urandom & 32'h3FFFFFFF);
         drive(1, d, 1'($urandom_range(0, 1)));
      end
      compared++;
      if (rep_valid !== 1'b1 || rep_max !== 32'hFFFFFFFF) begin
         mismatched++; $display("FAIL umax: got v=%b max=%h want 1 ffffffff", rep_valid, rep_max);
      end
   endtask
   task automatic test_reset_mid_batch;
      logic [31:0] x, m, d;
      for (int k = 0; k <= DEPTH; k++) drive(0, 0, 1);
      for (int i = 1; i <= 100; i++) drive(1, 32'h5000 + 32'(i), 1'(i < 99));
      compared++;
      if (out_valid !== 1'b1 || out_data !== 32'h5062) begin
         mismatched++; $display("FAIL rmb_buffered: got v=%b d=%h want 1 00005062", out_valid, out_data);
      end
      rst_n = 0; drive(0, 0, 0); rst_n = 1;
      compared++;
      if (out_valid !== 1'b0 || rep_valid !== 1'b0) begin
         mismatched++; $display("FAIL rmb_after_reset: got out_valid=%b rep_valid=%b want 0 0", out_valid, rep_valid);
      end
      drive(0, 0, 1);
      compared++;
      if (rep_valid !== 1'b0 || out_valid !== 1'b0) begin
         mismatched++; $display("FAIL rmb_no_report: got rep_valid=%b out_valid=%b want 0 0", rep_valid, out_valid);
      end
      x = '0; m = '0;
      for (int i = 0; i < 256; i++) begin
         d = $urandom;
         x ^= d;
         if (d > m) m = d;
         drive(1, d, 1);
      end
      compared++;
      if (rep_valid !== 1'b1 || rep_checksum !== x || rep_max !== m || rep_ovf !== 1'b0) begin
         mismatched++; $display("FAIL rmb_fresh_batch: got v=%b chk=%h max=%h ovf=%b want 1 %h %h 0", rep_valid, rep_checksum, rep_max, rep_ovf, x, m);
      end
   endtask
   initial begin
      test_reset;
      test_basic;
      test_overflow;
      test_full_push_pop;
      test_back_to_back;
      test_unsigned_max;
      test_reset_mid_batch;
      drive(0, 0, 1);
      drive(0, 0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/rand_collect.md
RAND_COLLECT -- requirements
Module: rand_collect

Interface
REQ-001 Parameter DEPTH, 4, number of entries in the output buffer (power of two, at least 2).
REQ-002 Parameter BATCH, 256, number of input words per batch report.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous and active-low, sampled on the clk rising edge.
REQ-005 Port in_valid  input  1  one random word is presented this cycle; the upstream stage has no backpressure.
REQ-006 Port in_data  input  32  random word, valid only while in_valid=1.
REQ-007 Port out_ready  input  1  the downstream stage accepts out_data this cycle.
REQ-008 Port out_valid  output  1  buffer is non-empty and out_data holds the head entry.
REQ-009 Port out_data  output  32  head entry of the buffer.
REQ-010 Port rep_valid  output  1  one-cycle pulse; the batch report is valid.
REQ-011 Port rep_checksum  output  32  XOR of all BATCH words in the batch.
REQ-012 Port rep_max  output  32  unsigned maximum word in the batch.
REQ-013 Port rep_ovf  output  1  at least one word of the batch was dropped because the buffer was full.

Function
REQ-014 The buffer SHALL be a single-clock FIFO of DEPTH entries, tracked by a write pointer, a read pointer and an occupancy count of clog2(DEPTH)+1 bits.
REQ-015 A word SHALL be written when in_valid=1 and the buffer is not full, or when it is full and a pop occurs in the same cycle.
REQ-016 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-017 out_valid SHALL equal (count != 0), and out_data SHALL be the storage entry at the read pointer.
REQ-018 Latency: a word written into an empty buffer at edge N SHALL appear on out_valid/out_data in the cycle after edge N, with no zero-cycle bypass.
REQ-019 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-020 Pointers SHALL wrap modulo DEPTH.
REQ-021 A word with in_valid=1 while full and with no pop in that cycle SHALL be dropped, and the batch overflow flag SHALL set and stay set until the batch reports.
REQ-022 Batch FSM states: IDLE, COLLECT, REPORT.
REQ-023 IDLE: with in_valid=1, go to COLLECT and load cnt=1, chk=in_data, max=in_data; otherwise hold.
REQ-024 COLLECT: for each in_valid=1, cnt+=1, chk^=in_data and max=max(max,in_data) unsigned.
REQ-025 COLLECT: when in_valid=1 and cnt==BATCH-1, the update SHALL be included and the FSM SHALL go to REPORT.
REQ-026 REPORT lasts exactly one cycle, with rep_valid=1 and rep_checksum/rep_max/rep_ovf holding the final batch values.
REQ-027 Leaving REPORT: with in_valid=1, go to COLLECT with cnt=1, chk=max=in_data and ovf=(that word dropped); otherwise go to IDLE with cnt, chk, max and ovf cleared.
REQ-028 Dropped words SHALL still count toward cnt, chk and max, because statistics cover the upstream stream and not the buffered stream.
REQ-029 The batch logic SHALL be independent of out_ready; backpressure never stalls counting.
REQ-030 rep_checksum, rep_max and rep_ovf SHALL be registered and hold their last reported values until the next REPORT.
REQ-031 BATCH=1 SHALL be supported: every accepted word SHALL produce a REPORT on the next cycle.

Reset
REQ-032 When rst_n=0 at a clk edge, pointers, count, cnt, chk, max, ovf and the FSM SHALL clear (FSM to IDLE), and out_valid, rep_valid, rep_checksum, rep_max and rep_ovf SHALL be 0 from the next cycle.
REQ-033 Reset mid-batch or with a non-empty buffer SHALL discard all buffered words and partial statistics, with no report emitted.
REQ-034 Buffer storage contents need no reset; out_data is don't-care while out_valid=0.

Verification
REQ-035 Basic: hold out_ready=1 and drive 256 words 1..256 back-to-back -> each word appears on out_data one cycle after input; rep_valid pulses once on the cycle after word 256, with rep_checksum=0x00000100 (XOR 1..256), rep_max=256 and rep_ovf=0.
REQ-036 Overflow: hold out_ready=0 and drive 6 words A0..A5 (DEPTH=4) -> count saturates at 4; A4 and A5 are dropped and ovf is set; releasing out_ready drains A0..A3 in order; completing the batch gives rep_ovf=1.
REQ-037 Full with simultaneous push and pop: buffer full, out_ready=1 and in_valid=1 in the same cycle -> the word is accepted, count stays 4 and no overflow is flagged.
REQ-038 Back-to-back batches: drive 512 continuous words -> exactly two rep_valid pulses, 256 cycles apart, and word 257 starts the second batch with no word lost from the statistics.
REQ-039 Reset mid-batch: apply rst_n=0 for 1 cycle after 100 words with 3 words buffered -> out_valid=0 next cycle and no rep_valid; a fresh 256-word batch then reports correct values from scratch.
REQ-040 Unsigned max: a batch containing 0xFFFFFFFF and 0x7FFFFFFF -> rep_max=0xFFFFFFFF.
